// File: rtl/pio_pkg.sv
// Shared constants for the input PIO family: register addresses, edge modes, width limit.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/pio_edge_capture_in_if.sv
// Avalon-MM slave bus bundle for the edge-capture input PIO.
interface pio_edge_capture_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_sync_chain.sv
// WIDTH-bit multi-flop synchronizer; output is the last stage of the chain.
module pio_sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_chain[s] <= r_chain[s-1];
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM input PIO: synchronized status lines, sticky W1C edge capture, IRQ mask, level IRQ.
module pio_edge_capture_in
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_edge_capture_in_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int CNT_W   = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] w_sync, r_prev, w_rise, w_fall, w_edge_sel, w_edge;
  logic [WIDTH-1:0] r_edgecap, w_mask, w_clr;
  logic [CNT_W-1:0] r_arm;
  logic             w_armed, w_wr;
  logic [31:0]      w_rdata, r_readdata;
  logic             w_unused_wdata;

  pio_sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (in_port),
    .o_q   (w_sync)
  );

  // Hold off capture until prev has seen a real synchronized sample,
  // so lines already high at reset release do not look like edges.
  assign w_armed = (r_arm == CNT_W'(ARM_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm  <= '0;
      r_prev <= '0;
    end else begin
      r_prev <= w_sync;
      if (!w_armed) r_arm <= r_arm + 1'b1;
    end
  end

  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  always_comb begin
    w_edge_sel = w_rise;
    case (EDGE_TYPE)
      EDGE_FALL: w_edge_sel = w_fall;
      EDGE_ANY:  w_edge_sel = w_rise | w_fall;
      default:   ;
    endcase
  end

  assign w_edge = w_armed ? w_edge_sel : '0;

  assign w_wr  = bus.chipselect & ~bus.write_n;
  assign w_clr = (w_wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  // Set dominates a simultaneous W1C of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_edgecap <= '0;
    else          r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
  end

  generate
    if (IRQ_EN != 0) begin : g_mask
      logic [WIDTH-1:0] r_mask;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                r_mask <= '0;
        else if (w_wr && bus.address == ADDR_IRQMASK) r_mask <= bus.writedata[WIDTH-1:0];
      end
      assign w_mask = r_mask;
    end else begin : g_nomask
      assign w_mask = '0;
    end
  endgenerate

  assign irq = |(r_edgecap & w_mask);

  // Bits of writedata above WIDTH have no register behind them.
  assign w_unused_wdata = ^bus.writedata;

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA:    w_rdata[WIDTH-1:0] = w_sync;
      ADDR_IRQMASK: w_rdata[WIDTH-1:0] = w_mask;
      ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rdata;
  end

  assign bus.readdata = r_readdata;

endmodule
